unzigzag: RTL and testbench

Inverse zigzag reorder buffer for the JPEG decode path. It accepts one 8x8 block of quantised DCT coefficients in zigzag scan order, one per cycle, and emits them in natural column-major order (natural index n = col*8 + row) for the IDCT column pass. Two 64-entry banks are used ping-pong, so one block is written while the previous block is read out. It mirrors the encoder-side zigzag block and uses the same four-wire handshake.

---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/coef_pingpong_buf.sv | 73 +++++++
 rtl/unzigzag.sv | 69 ++++++
 tb/tb_unzigzag.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient width, block size and the zigzag scan table
// (zigzag position -> natural column-major index col*8+row).
package jpeg_pkg;

  localparam int unsigned CoefWidth = 11;
  localparam int unsigned BlockSize = 64;
  localparam int unsigned AddrWidth = 6;

  typedef logic [AddrWidth-1:0] coef_addr_t;

  localparam coef_addr_t ZZ [BlockSize] = '{
    6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
    6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
    6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
    6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
    6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
    6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
    6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
    6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
  };

  function automatic coef_addr_t zz_to_natural(input coef_addr_t k);
    return ZZ[k];
  endfunction

endpackage

// File: rtl/coef_pingpong_buf.sv
// Two 64-entry coefficient banks used ping-pong: one bank is filled while the other drains.
// Each bank carries a FULL flag; write and read bank selects toggle on block completion.
module coef_pingpong_buf
  import jpeg_pkg::*;
#(
  parameter int unsigned WIDTH = CoefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  // write port
  input  logic             wr_en_i,
  input  coef_addr_t       wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_last_i,
  output logic             wr_rdy_o,
  // read port
  input  logic             rd_adv_i,
  input  coef_addr_t       rd_addr_i,
  input  logic             rd_last_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [2][BlockSize];
  logic [1:0]       full_q, full_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic             wr_fire, rd_fire;

  assign wr_rdy_o   = ~full_q[wb_q];
  assign rd_valid_o = full_q[rb_q];
  assign wr_fire    = wr_en_i & wr_rdy_o;
  assign rd_fire    = rd_adv_i & rd_valid_o;

  // Output is forced to zero whenever no block is being presented.
  assign rd_data_o = rd_valid_o ? mem_q[rb_q][rd_addr_i] : '0;

  // Write and read can never target the same bank in one cycle (one needs it empty,
  // the other full), so both flag updates can be applied independently.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    if (wr_fire && wr_last_i) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
    if (rd_fire && rd_last_i) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
    end
  end

  // Bank storage needs no reset; contents are only observed once a bank is FULL.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wb_q][wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/unzigzag.sv
// Inverse zigzag reorder: accepts a block in zigzag scan order and emits it in natural
// column-major order, with one block buffered while the previous one drains.
module unzigzag
  import jpeg_pkg::*;
#(
  parameter int unsigned WIDTH = CoefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_in,
  output logic             rdy_out,
  input  logic [WIDTH-1:0] in,
  output logic             ena_out,
  input  logic             rdy_in,
  output logic [WIDTH-1:0] out
);

  coef_addr_t wk_q, wk_d;
  coef_addr_t rn_q, rn_d;
  coef_addr_t wr_addr;
  logic       in_xfer, out_xfer;
  logic       wr_last, rd_last;

  assign in_xfer  = ena_in & rdy_out;
  assign out_xfer = ena_out & rdy_in;
  assign wr_addr  = zz_to_natural(wk_q);
  assign wr_last  = (wk_q == coef_addr_t'(BlockSize - 1));
  assign rd_last  = (rn_q == coef_addr_t'(BlockSize - 1));

  // Counters wrap naturally at 64, which lines up with the bank toggle.
  always_comb begin
    wk_d = wk_q;
    rn_d = rn_q;
    if (in_xfer) begin
      wk_d = wk_q + 6'd1;
    end
    if (out_xfer) begin
      rn_d = rn_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wk_q <= '0;
      rn_q <= '0;
    end else begin
      wk_q <= wk_d;
      rn_q <= rn_d;
    end
  end

  coef_pingpong_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (ena_in),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (in),
    .wr_last_i  (wr_last),
    .wr_rdy_o   (rdy_out),
    .rd_adv_i   (rdy_in),
    .rd_addr_i  (rn_q),
    .rd_last_i  (rd_last),
    .rd_valid_o (ena_out),
    .rd_data_o  (out)
  );

endmodule

// File: tb/tb_unzigzag.sv
// Scoreboard bench for unzigzag: stimulus pushes expected natural-order words, a monitor
// pops and compares on every output transfer and checks stability under backpressure.
module tb_unzigzag;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [10:0] din = '0;
  logic        rdy_out, ena_out;
  logic [10:0] dout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  int zz_tb[64] = '{
     0,  8,  1,  2,  9, 16, 24, 17, 10,  3,  4, 11, 18, 25, 32, 40,
    33, 26, 19, 12,  5,  6, 13, 20, 27, 34, 41, 48, 56, 49, 42, 35,
    28, 21, 14,  7, 15, 22, 29, 36, 43, 50, 57, 58, 51, 44, 37, 30,
    23, 31, 38, 45, 52, 59, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
  };

  always #5 clk = ~clk;

  unzigzag #(
    .WIDTH (11)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena_in  (ena_in),
    .rdy_out (rdy_out),
    .in      (din),
    .ena_out (ena_out),
    .rdy_in  (rdy_in),
    .out     (dout)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, transfers happen on the next rise.
  initial begin
    logic        stall;
    logic [10:0] held;
    int          e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_ena_out", int'(ena_out), 1);
          check("stall_out_stable", int'(dout), int'(held));
        end
        if (ena_out && rdy_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0d, required no output", dout);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(dout), e);
          end
        end
        if (!ena_out) check("idle_out_zero", int'(dout), 0);
        stall = ena_out && !rdy_in;
        held  = dout;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic put_word(input int v);
    bit ok;
    ok     = 1'b0;
    ena_in = 1'b1;
    din    = 11'(v);
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = rdy_out;
      @(posedge clk);
      #1;
    end
    ena_in = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL put_word_timeout: word %0d not accepted, rdy_out=%0b required 1", v,
               rdy_out);
    end
  endtask

  // zz_mode: in[k] = ZZ[k]+base, so natural output is base+n.
  // otherwise: in[k] = k+base, so natural index ZZ[k] carries k+base.
  task automatic send_block(input int base, input bit zz_mode, input int gap_at,
                            input bit chk_lat);
    int e[64];
    for (int k = 0; k < 64; k++) begin
      if (k == gap_at) repeat (5) begin @(posedge clk); #1; end
      put_word(zz_mode ? zz_tb[k] + base : k + base);
    end
    for (int n = 0; n < 64; n++) e[n] = base + n;
    if (!zz_mode) for (int k = 0; k < 64; k++) e[zz_tb[k]] = base + k;
    for (int n = 0; n < 64; n++) exp_q.push_back(e[n]);
    if (chk_lat) begin
      check("latency_ena_out", int'(ena_out), 1);
      check("latency_first_out", int'(dout), base);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gaps;
    int early;
    int t;

    #12;
    check("reset_ena_out", int'(ena_out), 0);
    check("reset_rdy_out", int'(rdy_out), 1);
    check("reset_out", int'(dout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single block, then the positional block (in[k] = k).
    rdy_in = 1'b1;
    send_block(0, 1'b1, -1, 1'b1);
    wait_drain();
    check("single_ena_out_after", int'(ena_out), 0);
    send_block(0, 1'b0, -1, 1'b1);
    wait_drain();

    // Ping-pong: two blocks held, a third word ignored, then drain without bubbles.
    rdy_in = 1'b0;
    send_block(0, 1'b1, -1, 1'b0);
    send_block(100, 1'b1, -1, 1'b0);
    check("pp_rdy_out_low", int'(rdy_out), 0);
    check("pp_ena_out_high", int'(ena_out), 1);
    ena_in = 1'b1;
    din    = 11'd999;
    repeat (3) begin @(posedge clk); #1; end
    ena_in = 1'b0;
    rdy_in = 1'b1;
    gaps   = 0;
    early  = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (!ena_out) gaps++;
      if (i < 64 && rdy_out) early++;
      if (i == 64) check("pp_rdy_out_return", int'(rdy_out), 1);
      @(posedge clk);
      #1;
    end
    check("pp_no_gap", gaps, 0);
    check("pp_rdy_out_held_low", early, 0);
    wait_drain();

    // Random backpressure during readout.
    rdy_in = 1'b0;
    send_block(200, 1'b0, -1, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      rdy_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      t++;
    end
    rdy_in = 1'b1;
    wait_drain();

    // Input gap of 5 cycles at k = 20.
    send_block(0, 1'b1, 20, 1'b1);
    wait_drain();

    // Reset with one block pending and a partial block in progress.
    rdy_in = 1'b0;
    send_block(0, 1'b1, -1, 1'b0);
    for (int k = 0; k < 30; k++) put_word(zz_tb[k] + 50);
    check("pre_reset_ena_out", int'(ena_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_ena_out", int'(ena_out), 0);
    check("mid_reset_rdy_out", int'(rdy_out), 1);
    check("mid_reset_out", int'(dout), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    send_block(0, 1'b1, -1, 1'b1);
    wait_drain();
    check("final_ena_out", int'(ena_out), 0);
    check("final_rdy_out", int'(rdy_out), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
